// File: rtl/traff_light_disp.sv
// Countdown display driver for the traffic-light lamp/remaining-time interface.
// Optional 1 Hz yellow blink is enabled by defining TRAFF_DISP_BLINK_EN.
module traff_light_disp #(
  parameter int MS_PER_S    = 1000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tick_1ms,
  input  logic [2:0] light,
  input  logic [3:0] light_t,
  output logic [7:0] seg,
  output logic [1:0] dig_sel,
  output logic [3:0] remain,
  output logic       expired,
  output logic       fault
);

  localparam int              MS_W      = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
  localparam logic [MS_W-1:0] MS_LAST   = MS_W'(MS_PER_S - 1);
  localparam logic [7:0]      SEG_BLANK = 8'hFF;
  localparam logic [7:0]      SEG_DASH  = 8'hBF;
  localparam logic [7:0]      SEG_RST   = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [1:0]      DIG_RST   = SEG_ACT_LOW ? 2'b11 : 2'b00;
`ifdef TRAFF_DISP_BLINK_EN
  localparam logic [MS_W-1:0] MS_HALF   = MS_W'(MS_PER_S / 2);
`endif

  typedef enum logic [1:0] {
    CLS_OFF = 2'd0,
    CLS_RUN = 2'd1,
    CLS_ILL = 2'd2
  } light_cls_e;

  // Active-low 7-segment pattern {dp,g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic light_cls_e classify(input logic [2:0] l);
    light_cls_e c;
    case (l)
      3'b000:                 c = CLS_OFF;
      3'b100, 3'b010, 3'b001: c = CLS_RUN;
      default:                c = CLS_ILL;
    endcase
    return c;
  endfunction

  logic [2:0]      r_light_q;
  logic [MS_W-1:0] r_ms_cnt;
  logic [3:0]      r_remain;
  logic            r_expired;
  logic            r_fault;
  logic            r_scan_on;
  logic            r_idx_tens;
  logic [7:0]      r_seg;
  logic [1:0]      r_dig_sel;

  light_cls_e      w_cls;
  logic            w_load;
  logic [MS_W-1:0] w_ms_nxt;
  logic [3:0]      w_remain_nxt;
  logic            w_dec;
  logic            w_expired_nxt;
  logic            w_fault_nxt;
  logic            w_scan_nxt;
  logic            w_idx_nxt;
  logic            w_blink;
  logic            w_tens;
  logic [3:0]      w_ones;
  logic [7:0]      w_seg_al;
  logic [1:0]      w_dig_al;

  // Countdown next state: load beats a same-cycle wrap; illegal codes freeze.
  always_comb begin
    w_cls        = classify(light);
    w_load       = 1'b0;
    w_ms_nxt     = r_ms_cnt;
    w_remain_nxt = r_remain;
    w_dec        = 1'b0;
    w_fault_nxt  = r_fault;
    if ((w_cls == CLS_RUN) && (light != r_light_q)) begin
      w_load       = 1'b1;
      w_ms_nxt     = '0;
      w_remain_nxt = light_t;
    end else if (w_cls == CLS_OFF) begin
      w_ms_nxt     = '0;
      w_remain_nxt = 4'd0;
    end else if (w_cls == CLS_ILL) begin
      w_fault_nxt  = 1'b1;
    end else if (tick_1ms) begin
      if (r_ms_cnt == MS_LAST) begin
        w_ms_nxt = '0;
        if (r_remain != 4'd0) begin
          w_remain_nxt = r_remain - 4'd1;
          w_dec        = 1'b1;
        end else begin
          w_remain_nxt = r_remain;
        end
      end else begin
        w_ms_nxt = r_ms_cnt + MS_W'(1);
      end
    end else begin
      w_ms_nxt = r_ms_cnt;
    end
    w_expired_nxt = w_dec && (r_remain == 4'd1);
  end

  // Scan index toggles on every tick once the first scan has started.
  always_comb begin
    w_scan_nxt = r_scan_on | tick_1ms;
    if (tick_1ms) begin
      w_idx_nxt = ~r_idx_tens;
    end else begin
      w_idx_nxt = r_idx_tens;
    end
  end

  // Display content is derived from next-state values so seg always matches remain.
  always_comb begin
`ifdef TRAFF_DISP_BLINK_EN
    w_blink = (light == 3'b010) && (w_ms_nxt >= MS_HALF);
`else
    w_blink = 1'b0;
`endif
    w_tens   = (w_remain_nxt >= 4'd10);
    w_ones   = w_remain_nxt - (w_tens ? 4'd10 : 4'd0);
    w_seg_al = SEG_BLANK;
    w_dig_al = 2'b11;
    if (!w_scan_nxt) begin
      w_seg_al = SEG_BLANK;
      w_dig_al = 2'b11;
    end else begin
      w_dig_al = w_idx_nxt ? 2'b01 : 2'b10;
      case (w_cls)
        CLS_OFF: w_seg_al = SEG_BLANK;
        CLS_ILL: w_seg_al = SEG_DASH;
        CLS_RUN: begin
          if (w_blink) begin
            w_seg_al = SEG_BLANK;
          end else if (w_idx_nxt) begin
            w_seg_al = w_tens ? seg_digit(4'd1) : SEG_BLANK;
          end else begin
            w_seg_al = seg_digit(w_ones);
          end
        end
        default: w_seg_al = SEG_BLANK;
      endcase
    end
  end

  // Phase tracking and countdown state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_light_q <= 3'b000;
      r_ms_cnt  <= '0;
      r_remain  <= 4'd0;
      r_expired <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_light_q <= light;
      r_ms_cnt  <= w_ms_nxt;
      r_remain  <= w_remain_nxt;
      r_expired <= w_expired_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  // Scan state and registered display outputs with selectable polarity.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scan_on  <= 1'b0;
      r_idx_tens <= 1'b0;
      r_seg      <= SEG_RST;
      r_dig_sel  <= DIG_RST;
    end else begin
      r_scan_on  <= w_scan_nxt;
      r_idx_tens <= w_idx_nxt;
      r_seg      <= SEG_ACT_LOW ? w_seg_al : ~w_seg_al;
      r_dig_sel  <= SEG_ACT_LOW ? w_dig_al : ~w_dig_al;
    end
  end

  assign seg     = r_seg;
  assign dig_sel = r_dig_sel;
  assign remain  = r_remain;
  assign expired = r_expired;
  assign fault   = r_fault;

endmodule

// File: tb/tb_traff_light_disp.sv
// Self-checking bench for traff_light_disp with a behavioural countdown/display model.
module tb_traff_light_disp;

  localparam int MS = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       tick_1ms;
  logic [2:0] light;
  logic [3:0] light_t;
  logic [7:0] seg;
  logic [1:0] dig_sel;
  logic [3:0] remain;
  logic       expired;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model state
  int         m_remain, m_ms;
  logic [2:0] m_prev, m_light;
  bit         m_fault, m_started, m_tens, m_expired;

  traff_light_disp #(.MS_PER_S(MS), .SEG_ACT_LOW(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_1ms(tick_1ms),
    .light(light), .light_t(light_t), .seg(seg), .dig_sel(dig_sel),
    .remain(remain), .expired(expired), .fault(fault)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic bit is_onehot(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  task automatic model_reset();
    m_remain = 0; m_ms = 0; m_prev = 3'b000; m_light = 3'b000;
    m_fault = 0; m_started = 0; m_tens = 0; m_expired = 0;
  endtask

  task automatic model_update(input logic tk, input logic [2:0] l, input logic [3:0] lt);
    m_expired = 0;
    if (is_onehot(l) && l != m_prev) begin
      m_remain = lt; m_ms = 0;
    end else if (l == 3'b000) begin
      m_remain = 0; m_ms = 0;
    end else if (!is_onehot(l)) begin
      m_fault = 1;
    end else if (tk) begin
      m_ms = (m_ms + 1) % MS;
      if (m_ms == 0 && m_remain > 0) begin
        m_expired = (m_remain == 1);
        m_remain  = m_remain - 1;
      end
    end
    if (tk) begin
      m_started = 1;
      m_tens    = !m_tens;
    end
    m_prev  = l;
    m_light = l;
  endtask

  function automatic bit m_blank_blink();
`ifdef TRAFF_DISP_BLINK_EN
    return (m_light == 3'b010) && (m_ms >= MS / 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [7:0] s;
    logic [1:0] d;
    if (!m_started) begin
      s = 8'hFF; d = 2'b11;
    end else begin
      d = m_tens ? 2'b01 : 2'b10;
      if (m_light == 3'b000)      s = 8'hFF;
      else if (!is_onehot(m_light)) s = 8'hBF;
      else if (m_blank_blink())   s = 8'hFF;
      else if (m_tens)            s = (m_remain >= 10) ? seg_tab[m_remain / 10] : 8'hFF;
      else                        s = seg_tab[m_remain % 10];
    end
    return {s, d, 4'(m_remain), m_expired, m_fault};
  endfunction

  // One clock: drive inputs, let the edge pass, update the model, sample #1 later.
  task automatic step(input logic tk, input logic [2:0] l, input logic [3:0] lt);
    tick_1ms = tk; light = l; light_t = lt;
    @(posedge sys_clk);
    model_update(tk, l, lt);
    #1;
    tick_1ms = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; tick_1ms = 1'b0; light = 3'b000; light_t = 4'd0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    n_tests++;
    if ({seg, dig_sel, remain, expired, fault} !== {8'hFF, 2'b11, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values got %h want %h", {seg, dig_sel, remain, expired, fault},
               {8'hFF, 2'b11, 4'd0, 1'b0, 1'b0});
    end
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 3'b000, 4'($urandom));
      step(1'b1, 3'b000, 4'($urandom));
      n_tests++;
      if ({seg, dig_sel, remain, expired, fault} !==
          {8'hFF, ((k % 2) == 1) ? 2'b01 : 2'b10, 4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL off_scan tick=%0d got seg=%h dig=%b rem=%0d exp=%b flt=%b", k,
                 seg, dig_sel, remain, expired, fault);
      end
    end
  endtask

  task automatic test_countdown();
    int ticks = 0;
    int pulses = 0;
    step(1'b0, 3'b100, 4'd10);
    n_tests++;
    if (remain !== 4'd10 || seg !== (m_tens ? 8'hF9 : 8'hC0)) begin
      n_fail++;
      $display("FAIL load_10 got rem=%0d seg=%h want rem=10 seg=%h", remain, seg,
               m_tens ? 8'hF9 : 8'hC0);
    end
    while (ticks < 48) begin
      repeat ($urandom_range(0, 2)) begin
        step(1'b0, 3'b100, 4'($urandom));
        n_tests++;
        if ({seg, dig_sel, remain, expired, fault} !== exp_vec()) begin
          n_fail++;
          $display("FAIL countdown_idle got %h want %h", {seg, dig_sel, remain, expired, fault}, exp_vec());
        end
      end
      step(1'b1, 3'b100, 4'($urandom));
      ticks++;
      if (expired === 1'b1) pulses++;
      n_tests++;
      if (expired !== (ticks == 40) || {seg, dig_sel, remain, expired, fault} !== exp_vec()) begin
        n_fail++;
        $display("FAIL countdown_tick%0d got %h want %h", ticks,
                 {seg, dig_sel, remain, expired, fault}, exp_vec());
      end
    end
    n_tests++;
    if (pulses != 1 || remain !== 4'd0) begin
      n_fail++;
      $display("FAIL expired_count got pulses=%0d rem=%0d want pulses=1 rem=0", pulses, remain);
    end
  endtask

  task automatic test_load_on_wrap();
    for (int g = 0; g < MS && m_ms != MS - 1; g++) step(1'b1, 3'b100, 4'd0);
    step(1'b1, 3'b010, 4'd5);
    n_tests++;
    if (remain !== 4'd5 || seg !== (m_tens ? 8'hFF : 8'h92)) begin
      n_fail++;
      $display("FAIL wrap_load got rem=%0d seg=%h want rem=5 seg=%h", remain, seg,
               m_tens ? 8'hFF : 8'h92);
    end
    for (int k = 1; k <= MS; k++) begin
      step(1'b1, 3'b010, 4'($urandom));
      n_tests++;
      if (remain !== ((k < MS) ? 4'd5 : 4'd4) || {seg, dig_sel, remain, expired, fault} !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_restart k=%0d got rem=%0d want %0d", k, remain, (k < MS) ? 5 : 4);
      end
    end
  endtask

  task automatic test_fault();
    logic [3:0] frozen;
    frozen = remain;
    for (int k = 0; k < 6; k++) begin
      step(1'($urandom_range(0, 1)), 3'b011, 4'($urandom));
      n_tests++;
      if (fault !== 1'b1 || remain !== frozen || (m_started && seg !== 8'hBF)) begin
        n_fail++;
        $display("FAIL illegal got flt=%b rem=%0d seg=%h want flt=1 rem=%0d seg=bf", fault,
                 remain, seg, frozen);
      end
    end
    step(1'b0, 3'b001, 4'd15);
    n_tests++;
    if (remain !== 4'd15 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_recover got rem=%0d flt=%b want rem=15 flt=1", remain, fault);
    end
    repeat (MS) step(1'b1, 3'b001, 4'($urandom));
    n_tests++;
    if (remain !== 4'd14 || fault !== 1'b1 || {seg, dig_sel, remain, expired, fault} !== exp_vec()) begin
      n_fail++;
      $display("FAIL fault_resume got rem=%0d flt=%b want rem=14 flt=1", remain, fault);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 3'b100, 4'd9);
    repeat (2 * MS) step(1'b1, 3'b100, 4'd0);
    n_tests++;
    if (remain !== 4'd7) begin
      n_fail++;
      $display("FAIL pre_reset got rem=%0d want 7", remain);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({seg, dig_sel, remain, expired, fault} !== {8'hFF, 2'b11, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset got %h want %h", {seg, dig_sel, remain, expired, fault},
               {8'hFF, 2'b11, 4'd0, 1'b0, 1'b0});
    end
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    step(1'b0, 3'b100, 4'd6);
    n_tests++;
    if (remain !== 4'd6 || {seg, dig_sel, remain, expired, fault} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reload_after_reset got rem=%0d want 6", remain);
    end
  endtask

  task automatic test_phase_display();
    step(1'b0, 3'b010, 4'd3);
    for (int k = 0; k < 3 * MS; k++) begin
      step(1'b1, 3'b010, 4'($urandom));
      n_tests++;
      if ({seg, dig_sel, remain, expired, fault} !== exp_vec()) begin
        n_fail++;
        $display("FAIL yellow k=%0d got %h want %h", k, {seg, dig_sel, remain, expired, fault}, exp_vec());
      end
    end
    step(1'b0, 3'b100, 4'd12);
    for (int k = 0; k < 3 * MS; k++) begin
      step(1'b1, 3'b100, 4'($urandom));
      n_tests++;
      if ((!m_tens && seg === 8'hFF) || {seg, dig_sel, remain, expired, fault} !== exp_vec()) begin
        n_fail++;
        $display("FAIL green k=%0d got %h want %h", k, {seg, dig_sel, remain, expired, fault}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] l;
    l = 3'b100;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 4))
          0:       l = 3'b000;
          1:       l = 3'b100;
          2:       l = 3'b010;
          3:       l = 3'b001;
          default: l = 3'($urandom);
        endcase
      end
      step(1'($urandom_range(0, 2) == 0), l, 4'($urandom));
      n_tests++;
      if ({seg, dig_sel, remain, expired, fault} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random k=%0d light=%b got %h want %h", k, l,
                 {seg, dig_sel, remain, expired, fault}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_load_on_wrap();
    test_fault();
    test_reset_mid();
    test_phase_display();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traff_light_disp.md
Name: traff_light_disp

Overview:
- Countdown display driver on the consuming side of the traffic-light controller's light/remaining-time interface.
- Watches the 3-bit lamp code and the 4-bit phase duration.
- Reloads a seconds countdown on each phase change and decrements it from a 1 ms tick.
- Drives a 2-digit, time-multiplexed, active-low 7-segment display; flags illegal lamp codes and pulses when a phase expires.

Parameters:
- MS_PER_S, 1000, tick_1ms pulses per displayed second (bench uses 4).
- SEG_ACT_LOW, 1, 1 = segment/digit outputs active-low; 0 = inverted polarity on seg and dig_sel.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- tick_1ms  in  1  single-cycle strobe, once per ms, synchronous to sys_clk.
- light  in  3  lamp code: 100 green, 010 yellow, 001 red, 000 off.
- light_t  in  4  phase duration in seconds, 0..15; sampled only on load.
- seg  out  8  {dp,g,f,e,d,c,b,a}; dp always inactive.
- dig_sel  out  2  digit enable; bit1 tens, bit0 ones; exactly one active after the first scan.
- remain  out  4  current seconds remaining, binary.
- expired  out  1  one-cycle pulse when remain goes 1 -> 0.
- fault  out  1  sticky illegal-lamp flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (sys_clk, sys_rst_n).
- Reset values:
  - seg = 8'hFF (blank), dig_sel = 2'b11 (both off).
  - remain = 0, expired = 0, fault = 0.
  - Internal: ms_cnt = 0, light_q = 000, digit index = ones.
- Phase tracking:
  - light_q registers light every cycle.
  - load = (light != light_q) and light is legal one-hot.
- Load: remain <= light_t, ms_cnt <= 0. Effective next cycle. light_t = 0 loads 0 with no expired pulse.
- Seconds count: on tick_1ms, ms_cnt increments.
  - At MS_PER_S-1, ms_cnt wraps to 0.
  - If remain > 0, remain decrements; remain saturates at 0, never wraps to 15.
- Priority: load beats a same-cycle wrap. The counter restarts and the wrap's decrement is discarded.
- expired: high exactly one cycle, the cycle after a decrement from 1 to 0. Never asserted by load or reset.
- light = 000 (off):
  - remain <= 0, ms_cnt held at 0, display blank (seg FF on both digits).
  - Scanning continues; no fault.
- Illegal code (any value other than 000/100/010/001):
  - fault <= 1 and stays set until reset.
  - Both digits show dash 8'hBF; countdown frozen.
  - A later legal code causes a load and resumes counting; fault stays high.
- Digit split: tens = (remain >= 10); ones = remain - 10*tens. Tens digit is blanked when 0.
- Encodings (active-low):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
  - Blank FF, dash BF.
- Scan:
  - Each tick_1ms toggles the digit index.
  - dig_sel = 2'b01 (tens on) or 2'b10 (ones on), active-low.
  - seg and dig_sel are registered and change in the same cycle, one cycle after the tick.
- Reset mid-phase: outputs return to their reset values immediately. After release, a legal light is seen as a change from 000 and loads.
- SEG_ACT_LOW = 0: seg and dig_sel are the bitwise inverse of the above, including reset values.

Optional Feature:
- Macro: TRAFF_DISP_BLINK_EN.
- Defined: in yellow (010), both digits are forced blank while ms_cnt >= MS_PER_S/2, giving a 1 Hz blink. remain and expired are unaffected.
- Undefined: steady display in all phases.

Test Plan:
- Reset, then release with light = 000 -> seg = FF, dig_sel alternates 01/10 per tick, remain = 0, expired = 0, fault = 0.
- MS_PER_S = 4; light 000 -> 100 with light_t = 10:
  - Next cycle remain = 10; display "10" (tens F9, ones C0).
  - After 40 ticks remain = 0; expired pulses once, at tick 40.
  - Ticks 44+: no further pulse.
- light 100 -> 010 with light_t = 5, on the same cycle as a tick wrap -> remain = 5, ms_cnt = 0, no decrement; tens blank (FF), ones 92.
- light = 011 -> fault = 1, both digits BF, remain frozen. Then light = 001 with light_t = 15 -> remain = 15, counting resumes, fault stays 1.
- sys_rst_n pulsed low mid-countdown at remain = 7 -> same cycle seg = FF, dig_sel = 11, remain = 0. After release, light = 100 reloads light_t.
- TRAFF_DISP_BLINK_EN defined, light = 010, light_t = 3, MS_PER_S = 4:
  - Digits blank during ms_cnt 2..3 of each second, visible during 0..1.
  - Green phase never blanks.
